apb_fsm_controller: RTL and testbench
=====================================

# apb_fsm_controller

APB-side transfer sequencer of the AHB-to-APB bridge. Sits directly downstream of `AHB_slave_interface` and consumes its outputs: `valid`, pipelined address/data, registered write flag and slave select. Converts accepted AHB transfers into two-phase APB SETUP/ENABLE cycles for three peripherals. Generates `Hreadyout` to stall the AHB master while an APB access is in flight.

## Interface
Parameters:
- none (address map constants live in the package)

Ports:
- `Hclk` in 1: bridge clock, rising edge.
- `Hreset` in 1: asynchronous, active-high reset.
- `valid` in 1: current AHB address phase is an accepted NONSEQ/SEQ transfer in the APB window.
- `Hwrite` in 1: write flag of the current address phase.
- `Hwritereg` in 1: `Hwrite` registered one cycle.
- `Haddr` in 32: current AHB address.
- `Haddr1` in 32: `Haddr` registered one cycle.
- `Hwdata` in 32: current AHB write data (data phase).
- `tempselx` in 3: one-hot select decoded from `Haddr`.
- `Pselx` out 3: one-hot APB select.
- `Penable` out 1: APB enable.
- `Pwrite` out 1: APB direction.
- `Paddr` out 32: APB address.
- `Pwdata` out 32: APB write data.
- `Hreadyout` out 1: AHB ready back to master; looped to `Hreadyin` at top level.

## Operation
- All outputs are registered and update on the edge that enters a state; values listed per state are those held during that state.
- Reset (async, immediate): state `ST_IDLE`, `Pselx=0`, `Penable=0`, `Pwrite=0`, `Paddr=0`, `Pwdata=0`, `Hreadyout=1`.
- States, outputs and transitions:
  - `ST_IDLE`: `Pselx=0`, `Penable=0`, `Hreadyout=1`. Goes to `ST_READ` on `valid&~Hwrite`, to `ST_WWAIT` on `valid&Hwrite`, otherwise stays.
  - `ST_WWAIT`: idle APB outputs, `Hreadyout=1`; waits for write data. Goes to `ST_WRITEP` on `valid`, otherwise to `ST_WRITE`.
  - `ST_READ`: `Pselx=tempselx`, `Paddr=Haddr`, `Pwrite=0`, `Penable=0`, `Hreadyout=0`. Always goes to `ST_RENABLE`.
  - `ST_RENABLE`: `Penable=1`, `Hreadyout=1`; `Pselx`/`Paddr` held. Next state decided as in `ST_IDLE`.
  - `ST_WRITE` and `ST_WRITEP`: `Pselx=sel_decode(Haddr1)`, `Paddr=Haddr1`, `Pwdata=Hwdata`, `Pwrite=1`, `Penable=0`, `Hreadyout=0`. `ST_WRITE` goes to `ST_WENABLE`; `ST_WRITEP` goes to `ST_WENABLEP`.
  - `ST_WENABLE`: `Penable=1`, `Hreadyout=1`. Next state decided as in `ST_IDLE`.
  - `ST_WENABLEP`: `Penable=1`, `Hreadyout=Hwritereg`. Goes to `ST_WRITEP` if `Hwritereg&valid`, to `ST_WRITE` if `Hwritereg&~valid`, otherwise to `ST_READ` (pending read; `Haddr` still held by the master).
- Leaving any ENABLE state to `ST_IDLE` or `ST_WWAIT` clears `Pselx` and `Penable`. `Paddr`/`Pwdata` hold their last values.
- `Pselx` is never non-zero with an out-of-window address: `valid` gates entry, and `sel_decode` returns 0 outside the window.
- `Penable` is high only in the cycle directly after a SETUP cycle with identical `Pselx`/`Paddr`/`Pwrite`/`Pwdata`.

## Timing
- Read: `valid` in cycle 0; SETUP in cycle 1; ENABLE in cycle 2 with `Hreadyout=1`. One AHB wait state.
- Write: `valid` in cycle 0; `ST_WWAIT` in cycle 1; SETUP in cycle 2; ENABLE in cycle 3.
- Back-to-back writes: second address accepted in `ST_WWAIT`; each write then costs 2 cycles with `Hreadyout` low in SETUP.
- No APB wait states (`Pready` assumed 1); `Hresp` is handled upstream.
- Reset asserted mid-transfer: outputs clear immediately and the in-flight transfer is dropped.

## Structure
- Package `ahb2apb_pkg` holds:
  - state enum `apb_state_t` (8 states, 3-bit);
  - window constants `APB_BASE=32'h8000_0000`, `SLV_SIZE=32'h0400_0000`, `NUM_SLV=3`;
  - function `sel_decode(addr)` returning the one-hot 3-bit select, shared with the slave interface.
- Single module with no sub-modules: one `always_ff` for state+outputs, one `always_comb` for next-state.

## Test plan
- Reset mid-read (assert `Hreset` in SETUP) -> all outputs 0, `Hreadyout=1` the same cycle; IDLE after release.
- Single read of `32'h8400_0010` -> cycle 1 `Pselx=3'b010`, `Paddr=32'h8400_0010`, `Penable=0`, `Hreadyout=0`; cycle 2 `Penable=1`, `Hreadyout=1`; cycle 3 `Pselx=0`.
- Single write of `32'h8000_0004` with data `32'hDEAD_BEEF` -> cycle 2 `Pselx=3'b001`, `Pwrite=1`, `Pwdata=32'hDEAD_BEEF`; cycle 3 `Penable=1`.
- Burst of 4 writes to `32'h8800_0000`..`32'h8800_000C` -> four SETUP/ENABLE pairs, `Pselx=3'b100`, addresses in order, each `Pwdata` matching.
- Write followed immediately by read of `32'h8000_0020` -> `ST_WENABLEP` holds `Hreadyout=0`; then read SETUP with `Paddr=32'h8000_0020`, `Pwrite=0`.
- IDLE `Htrans`/out-of-window address (`32'h9000_0000`) -> `valid=0`, `Pselx` remains 0, `Hreadyout` remains 1.

Source files
------------

// File: rtl/ahb2apb_pkg.sv
// Shared definitions for the AHB-to-APB bridge: APB sequencer states, the
// peripheral address window and the one-hot select decoder.
`timescale 1ns/1ps
package ahb2apb_pkg;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_WWAIT    = 3'd1,
        ST_READ     = 3'd2,
        ST_WRITE    = 3'd3,
        ST_WRITEP   = 3'd4,
        ST_RENABLE  = 3'd5,
        ST_WENABLE  = 3'd6,
        ST_WENABLEP = 3'd7
    } apb_state_t;

    localparam logic [31:0] APB_BASE = 32'h8000_0000;
    localparam logic [31:0] SLV_SIZE = 32'h0400_0000;
    localparam int          NUM_SLV  = 3;

    // One-hot peripheral select; all zeros for any address outside the window.
    function automatic logic [2:0] sel_decode(input logic [31:0] addr);
        logic [31:0] off;
        logic [2:0]  sel;
        sel = 3'b000;
        off = addr - APB_BASE;
        if (addr >= APB_BASE) begin
            for (int i = 0; i < NUM_SLV; i++) begin
                if ((off >= SLV_SIZE * 32'(i)) && (off < SLV_SIZE * 32'(i + 1))) begin
                    sel[i] = 1'b1;
                end
            end
        end
        return sel;
    endfunction

endpackage

// File: rtl/apb_fsm_controller.sv
// APB-side sequencer of the AHB-to-APB bridge: turns accepted AHB transfers
// into APB SETUP/ENABLE pairs and stalls the AHB master while one is in flight.
`timescale 1ns/1ps
module apb_fsm_controller
    import ahb2apb_pkg::*;
(
    input  logic        Hclk,
    input  logic        Hreset,
    input  logic        valid,
    input  logic        Hwrite,
    input  logic        Hwritereg,
    input  logic [31:0] Haddr,
    input  logic [31:0] Haddr1,
    input  logic [31:0] Hwdata,
    input  logic [2:0]  tempselx,
    output logic [2:0]  Pselx,
    output logic        Penable,
    output logic        Pwrite,
    output logic [31:0] Paddr,
    output logic [31:0] Pwdata,
    output logic        Hreadyout
);

    apb_state_t  state;
    apb_state_t  next_state;

    logic [2:0]  pselx_d;
    logic        penable_d;
    logic        pwrite_d;
    logic [31:0] paddr_d;
    logic [31:0] pwdata_d;
    logic        hreadyout_d;

    always_ff @(posedge Hclk or posedge Hreset) begin
        if (Hreset) begin
            state     <= ST_IDLE;
            Pselx     <= 3'b000;
            Penable   <= 1'b0;
            Pwrite    <= 1'b0;
            Paddr     <= 32'h0;
            Pwdata    <= 32'h0;
            Hreadyout <= 1'b1;
        end else begin
            state     <= next_state;
            Pselx     <= pselx_d;
            Penable   <= penable_d;
            Pwrite    <= pwrite_d;
            Paddr     <= paddr_d;
            Pwdata    <= pwdata_d;
            Hreadyout <= hreadyout_d;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            ST_IDLE, ST_RENABLE, ST_WENABLE: begin
                if (valid && Hwrite) begin
                    next_state = ST_WWAIT;
                end else if (valid) begin
                    next_state = ST_READ;
                end else begin
                    next_state = ST_IDLE;
                end
            end
            // Write data arrives one cycle after the address; a new valid
            // address here means the next transfer is already queued.
            ST_WWAIT:    next_state = valid ? ST_WRITEP : ST_WRITE;
            ST_READ:     next_state = ST_RENABLE;
            ST_WRITE:    next_state = ST_WENABLE;
            ST_WRITEP:   next_state = ST_WENABLEP;
            ST_WENABLEP: begin
                if (Hwritereg && valid) begin
                    next_state = ST_WRITEP;
                end else if (Hwritereg) begin
                    next_state = ST_WRITE;
                end else begin
                    next_state = ST_READ;
                end
            end
            default:     next_state = ST_IDLE;
        endcase
    end

    // Outputs are computed for the state being entered and registered with it.
    always_comb begin
        pselx_d     = Pselx;
        penable_d   = Penable;
        pwrite_d    = Pwrite;
        paddr_d     = Paddr;
        pwdata_d    = Pwdata;
        hreadyout_d = Hreadyout;
        case (next_state)
            ST_IDLE, ST_WWAIT: begin
                pselx_d     = 3'b000;
                penable_d   = 1'b0;
                hreadyout_d = 1'b1;
            end
            ST_READ: begin
                pselx_d     = tempselx;
                paddr_d     = Haddr;
                pwrite_d    = 1'b0;
                penable_d   = 1'b0;
                hreadyout_d = 1'b0;
            end
            ST_WRITE, ST_WRITEP: begin
                pselx_d     = sel_decode(Haddr1);
                paddr_d     = Haddr1;
                pwdata_d    = Hwdata;
                pwrite_d    = 1'b1;
                penable_d   = 1'b0;
                hreadyout_d = 1'b0;
            end
            ST_RENABLE, ST_WENABLE: begin
                penable_d   = 1'b1;
                hreadyout_d = 1'b1;
            end
            // A pending read behind a write keeps the master stalled.
            ST_WENABLEP: begin
                penable_d   = 1'b1;
                hreadyout_d = Hwritereg;
            end
            default: begin
                pselx_d     = 3'b000;
                penable_d   = 1'b0;
                hreadyout_d = 1'b1;
            end
        endcase
    end

endmodule

// File: tb/tb_apb_fsm_controller.sv
// Scoreboard bench for apb_fsm_controller: directed AHB-side vectors with
// per-cycle expected APB outputs checked by an independent monitor.
`timescale 1ns/1ps
module tb_apb_fsm_controller;
    import ahb2apb_pkg::*;

    logic        Hclk = 1'b0;
    logic        Hreset = 1'b1;
    logic        valid = 1'b0;
    logic        Hwrite = 1'b0;
    logic        Hwritereg = 1'b0;
    logic [31:0] Haddr = 32'h0;
    logic [31:0] Haddr1 = 32'h0;
    logic [31:0] Hwdata = 32'h0;
    logic [2:0]  tempselx;
    logic [2:0]  Pselx;
    logic        Penable;
    logic        Pwrite;
    logic [31:0] Paddr;
    logic [31:0] Pwdata;
    logic        Hreadyout;

    apb_fsm_controller dut (
        .Hclk      (Hclk),
        .Hreset    (Hreset),
        .valid     (valid),
        .Hwrite    (Hwrite),
        .Hwritereg (Hwritereg),
        .Haddr     (Haddr),
        .Haddr1    (Haddr1),
        .Hwdata    (Hwdata),
        .tempselx  (tempselx),
        .Pselx     (Pselx),
        .Penable   (Penable),
        .Pwrite    (Pwrite),
        .Paddr     (Paddr),
        .Pwdata    (Pwdata),
        .Hreadyout (Hreadyout)
    );

    always #5 Hclk = ~Hclk;

    // Upstream slave-interface model: address decode and the registered
    // address/direction of the last completed address phase.
    assign tempselx = sel_decode(Haddr);
    always @(posedge Hclk) begin
        if (Hreadyout) begin
            Haddr1    <= Haddr;
            Hwritereg <= Hwrite;
        end
    end

    // mask bits: [5] Pselx [4] Penable [3] Pwrite [2] Paddr [1] Pwdata [0] Hreadyout
    typedef struct {
        string       nm;
        logic [5:0]  m;
        logic [2:0]  sel;
        logic        en;
        logic        wr;
        logic [31:0] addr;
        logic [31:0] wd;
        logic        rdy;
    } exp_t;

    exp_t q[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    localparam logic [5:0] M_ALL  = 6'b111111;
    localparam logic [5:0] M_IDLE = 6'b110001;
    localparam logic [5:0] M_RD   = 6'b111101;

    task automatic expect_o(input string nm, input logic [5:0] m, input logic [2:0] sel,
                            input logic en, input logic wr, input logic [31:0] addr,
                            input logic [31:0] wd, input logic rdy);
        exp_t e;
        e.nm = nm; e.m = m; e.sel = sel; e.en = en; e.wr = wr;
        e.addr = addr; e.wd = wd; e.rdy = rdy;
        q.push_back(e);
    endtask

    function automatic void chk(input string nm, input string fld,
                                input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s.%s: got %h, expected %h", nm, fld, act, req);
        end
    endfunction

    // Monitor: samples away from the clock edge, and right after an async reset.
    initial begin
        forever begin
            @(negedge Hclk or posedge Hreset);
            #1;
            if (q.size() > 0) begin
                exp_t e;
                e = q.pop_front();
                if (e.m[5]) chk(e.nm, "Pselx",     32'(Pselx),     32'(e.sel));
                if (e.m[4]) chk(e.nm, "Penable",   32'(Penable),   32'(e.en));
                if (e.m[3]) chk(e.nm, "Pwrite",    32'(Pwrite),    32'(e.wr));
                if (e.m[2]) chk(e.nm, "Paddr",     Paddr,          e.addr);
                if (e.m[1]) chk(e.nm, "Pwdata",    Pwdata,         e.wd);
                if (e.m[0]) chk(e.nm, "Hreadyout", 32'(Hreadyout), 32'(e.rdy));
            end
        end
    end

    task automatic cyc(input logic v, input logic w, input logic [31:0] a, input logic [31:0] d);
        @(posedge Hclk);
        #1;
        valid  = v;
        Hwrite = w;
        Haddr  = a;
        Hwdata = d;
    endtask

    function automatic logic [31:0] bd(input int k);
        return 32'hC0DE_0000 + 32'(k);
    endfunction

    function automatic logic [31:0] ba(input int k);
        return 32'h8800_0000 + 32'(4 * k);
    endfunction

    initial begin
        // Reset state and release
        cyc(0, 0, 32'h0, 32'h0);
        expect_o("rst_init", M_ALL, 3'b000, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1);
        cyc(0, 0, 32'h0, 32'h0);
        Hreset = 1'b0;
        expect_o("rst_rel", M_ALL, 3'b000, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1);

        // Reset asserted during a read SETUP
        cyc(1, 0, 32'h8000_0010, 32'h0);
        expect_o("mr_idle", M_IDLE, 3'b000, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1);
        cyc(0, 0, 32'h0, 32'h0);
        expect_o("mr_setup", M_RD, 3'b001, 1'b0, 1'b0, 32'h8000_0010, 32'h0, 1'b0);
        @(negedge Hclk);
        #2;
        expect_o("mr_rst", M_ALL, 3'b000, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1);
        Hreset = 1'b1;
        cyc(0, 0, 32'h0, 32'h0);
        expect_o("mr_hold", M_ALL, 3'b000, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1);
        cyc(0, 0, 32'h0, 32'h0);
        Hreset = 1'b0;
        expect_o("mr_rel", M_ALL, 3'b000, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1);
        cyc(0, 0, 32'h0, 32'h0);
        expect_o("mr_idle2", M_IDLE, 3'b000, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1);

        // Single read
        cyc(1, 0, 32'h8400_0010, 32'h0);
        expect_o("rd_c0", M_IDLE, 3'b000, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1);
        cyc(0, 0, 32'h0, 32'h0);
        expect_o("rd_setup", M_RD, 3'b010, 1'b0, 1'b0, 32'h8400_0010, 32'h0, 1'b0);
        cyc(0, 0, 32'h0, 32'h0);
        expect_o("rd_enable", M_RD, 3'b010, 1'b1, 1'b0, 32'h8400_0010, 32'h0, 1'b1);
        cyc(0, 0, 32'h0, 32'h0);
        expect_o("rd_done", 6'b110101, 3'b000, 1'b0, 1'b0, 32'h8400_0010, 32'h0, 1'b1);

        // Single write
        cyc(1, 1, 32'h8000_0004, 32'h0);
        expect_o("wr_c0", M_IDLE, 3'b000, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1);
        cyc(0, 0, 32'h0, 32'hDEAD_BEEF);
        expect_o("wr_wwait", M_IDLE, 3'b000, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1);
        cyc(0, 0, 32'h0, 32'h0);
        expect_o("wr_setup", M_ALL, 3'b001, 1'b0, 1'b1, 32'h8000_0004, 32'hDEAD_BEEF, 1'b0);
        cyc(0, 0, 32'h0, 32'h0);
        expect_o("wr_enable", M_ALL, 3'b001, 1'b1, 1'b1, 32'h8000_0004, 32'hDEAD_BEEF, 1'b1);
        cyc(0, 0, 32'h0, 32'h0);
        expect_o("wr_done", 6'b110111, 3'b000, 1'b0, 1'b0, 32'h8000_0004, 32'hDEAD_BEEF, 1'b1);

        // Burst of four writes to peripheral 2
        cyc(1, 1, ba(0), 32'h0);
        expect_o("bu_c0", M_IDLE, 3'b000, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1);
        cyc(1, 1, ba(1), bd(0));
        expect_o("bu_wwait", M_IDLE, 3'b000, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1);
        cyc(1, 1, ba(2), bd(1));
        expect_o("bu_setup0", M_ALL, 3'b100, 1'b0, 1'b1, ba(0), bd(0), 1'b0);
        cyc(1, 1, ba(2), bd(1));
        expect_o("bu_enable0", M_ALL, 3'b100, 1'b1, 1'b1, ba(0), bd(0), 1'b1);
        cyc(1, 1, ba(3), bd(2));
        expect_o("bu_setup1", M_ALL, 3'b100, 1'b0, 1'b1, ba(1), bd(1), 1'b0);
        cyc(1, 1, ba(3), bd(2));
        expect_o("bu_enable1", M_ALL, 3'b100, 1'b1, 1'b1, ba(1), bd(1), 1'b1);
        cyc(0, 0, 32'h0, bd(3));
        expect_o("bu_setup2", M_ALL, 3'b100, 1'b0, 1'b1, ba(2), bd(2), 1'b0);
        cyc(0, 0, 32'h0, bd(3));
        expect_o("bu_enable2", M_ALL, 3'b100, 1'b1, 1'b1, ba(2), bd(2), 1'b1);
        cyc(0, 0, 32'h0, 32'h0);
        expect_o("bu_setup3", M_ALL, 3'b100, 1'b0, 1'b1, ba(3), bd(3), 1'b0);
        cyc(0, 0, 32'h0, 32'h0);
        expect_o("bu_enable3", M_ALL, 3'b100, 1'b1, 1'b1, ba(3), bd(3), 1'b1);
        cyc(0, 0, 32'h0, 32'h0);
        expect_o("bu_done", M_IDLE, 3'b000, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1);

        // Write immediately followed by a read
        cyc(1, 1, 32'h8000_0008, 32'h0);
        expect_o("wr2rd_c0", M_IDLE, 3'b000, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1);
        cyc(1, 0, 32'h8000_0020, 32'h5555_AAAA);
        expect_o("wr2rd_wwait", M_IDLE, 3'b000, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1);
        cyc(0, 0, 32'h8000_0020, 32'h0);
        expect_o("wr2rd_wsetup", M_ALL, 3'b001, 1'b0, 1'b1, 32'h8000_0008, 32'h5555_AAAA, 1'b0);
        cyc(0, 0, 32'h8000_0020, 32'h0);
        expect_o("wr2rd_wenp", M_ALL, 3'b001, 1'b1, 1'b1, 32'h8000_0008, 32'h5555_AAAA, 1'b0);
        cyc(0, 0, 32'h0, 32'h0);
        expect_o("wr2rd_rsetup", M_ALL, 3'b001, 1'b0, 1'b0, 32'h8000_0020, 32'h5555_AAAA, 1'b0);
        cyc(0, 0, 32'h0, 32'h0);
        expect_o("wr2rd_renable", M_ALL, 3'b001, 1'b1, 1'b0, 32'h8000_0020, 32'h5555_AAAA, 1'b1);
        cyc(0, 0, 32'h0, 32'h0);
        expect_o("wr2rd_done", 6'b110101, 3'b000, 1'b0, 1'b0, 32'h8000_0020, 32'h0, 1'b1);

        // Out-of-window / idle transfers never start an APB access
        for (int i = 0; i < 3; i++) begin
            cyc(1'b0, 1'(i % 2), 32'h9000_0000, 32'h1234_5678);
            expect_o("oow", M_IDLE, 3'b000, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1);
        end
        cyc(0, 0, 32'h0, 32'h0);
        expect_o("oow_last", M_IDLE, 3'b000, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1);

        for (int i = 0; i < 20 && q.size() > 0; i++) @(negedge Hclk);
        #3;
        if (q.size() != 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL drain: %0d expectations left unchecked, expected 0", q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #50000;
        $display("FAIL timeout: simulation did not finish, expected completion");
        $fatal(1, "timeout");
    end

endmodule
